aes_128_sched: RTL and testbench



---
 rtl/aes_128_sched.sv | 180 ++++++++++++++++++
 tb/tb_aes_128_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_sched.sv
// aes_128_sched: shares one fully pipelined AES-128 core between NUM_REQ
// requesters. A round-robin arbiter issues at most one block per cycle, a
// valid/id/tag delay line follows each block through the core, and results
// land in a first-word-fall-through FIFO. A credit count covering in-flight
// blocks plus FIFO occupancy throttles issue, so the FIFO cannot overflow
// and the core never has to stall.
module aes_128_sched #(
  parameter  int NUM_REQ    = 2,
  parameter  int TAG_W      = 4,
  parameter  int LATENCY    = 21,
  parameter  int FIFO_DEPTH = 32,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*128-1:0]   req_state,
  input  logic [NUM_REQ*128-1:0]   req_key,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [127:0]             core_state,
  output logic [127:0]             core_key,
  input  logic [127:0]             core_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [127:0]             rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Arbitration / credit state
  logic [ID_W-1:0] last_ptr;
  logic [CW-1:0]   credit_used;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            can_issue;
  logic            issue;
  logic            pop;
  logic            push;

  // Per-requester views of the packed request buses
  logic [127:0]     state_arr [NUM_REQ];
  logic [127:0]     key_arr   [NUM_REQ];
  logic [TAG_W-1:0] tag_arr   [NUM_REQ];

  // Delay line tracking blocks inside the core
  logic [LATENCY-1:0] dl_valid;
  logic [ID_W-1:0]    dl_id  [LATENCY];
  logic [TAG_W-1:0]   dl_tag [LATENCY];

  // Result FIFO
  logic [127:0]     mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_count;

  // Unpack request buses and drive the one-hot grant
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign state_arr[gi] = req_state[128*gi +: 128];
      assign key_arr[gi]   = req_key[128*gi +: 128];
      assign tag_arr[gi]   = req_tag[TAG_W*gi +: TAG_W];
      assign req_ready[gi] = issue && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Round-robin search starting just after the last granted requester
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = last_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Registered credit only: no path from rsp_ready into the grant
  assign can_issue = !rst && (credit_used < CW'(FIFO_DEPTH));
  assign issue     = can_issue && grant_found;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = dl_valid[LATENCY-1];

  // Core input mux; zero when nothing issues so idle cycles are inert
  always_comb begin
    core_state = '0;
    core_key   = '0;
    if (issue) begin
      core_state = state_arr[grant_idx];
      core_key   = key_arr[grant_idx];
    end
  end

  // Remember the last granted requester; reset gives requester 0 priority
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ptr <= ID_W'(NUM_REQ - 1);
    end else if (issue) begin
      last_ptr <= grant_idx;
    end
  end

  // Valid bits of the delay line; clearing them drops in-flight blocks
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid <= '0;
    end else begin
      dl_valid[0] <= issue;
      for (int k = 1; k < LATENCY; k++) dl_valid[k] <= dl_valid[k-1];
    end
  end

  // id/tag payload of the delay line; meaningful only where valid is set
  always_ff @(posedge clk) begin
    dl_id[0]  <= grant_idx;
    dl_tag[0] <= tag_arr[grant_idx];
    for (int k = 1; k < LATENCY; k++) begin
      dl_id[k]  <= dl_id[k-1];
      dl_tag[k] <= dl_tag[k-1];
    end
  end

  // FIFO storage write; a stale write during reset is harmless
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= core_out;
      mem_id[wr_ptr]   <= dl_id[LATENCY-1];
      mem_tag[wr_ptr]  <= dl_tag[LATENCY-1];
    end
  end

  // FIFO pointers and occupancy; push and pop together keep the count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credit = in-flight + queued; a pop returns its credit next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_used <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credit_used <= credit_used + 1'b1;
        2'b01:   credit_used <= credit_used - 1'b1;
        default: credit_used <= credit_used;
      endcase
    end
  end

  // Head of FIFO falls through; outputs read zero while empty
  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : '0;
  assign rsp_tag   = rsp_valid ? mem_tag[rd_ptr]  : '0;
  assign busy      = (credit_used != '0);

endmodule

// File: tb/tb_aes_128_sched.sv
// Testbench for aes_128_sched with a pipelined stand-in for the AES core.
module tb_aes_128_sched;

  localparam int NUM_REQ    = 2;
  localparam int TAG_W      = 4;
  localparam int LATENCY    = 21;
  localparam int FIFO_DEPTH = 32;
  localparam int ID_W       = 1;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*128-1:0]   req_state;
  logic [NUM_REQ*128-1:0]   req_key;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [127:0]             core_state;
  logic [127:0]             core_key;
  logic [127:0]             core_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [127:0]             rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic                     busy;

  aes_128_sched #(
    .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_key(req_key), .req_tag(req_tag),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in core: known answer for the FIPS-197 pair, XOR otherwise
  function automatic logic [127:0] core_fn(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ k;
  endfunction

  logic [127:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_state, core_key);
    for (int k = 1; k < LATENCY; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign core_out = core_pipe[LATENCY-1];

  typedef struct {
    int           id;
    logic [3:0]   tag;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    int           req;
    logic [127:0] state;
    logic [127:0] key;
    logic [3:0]   tag;
    logic [127:0] exp_data;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   issue_cnt = 0;
  exp_t exp_q[$];
  int   grant_log[$];
  int   issue_edges[$];
  int   pop_edges[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: record issues, compare every pop in issue order
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      n_tests++;
      if ($countones(req_ready) > 1) begin
        n_fail++;
        $display("FAIL grant_onehot: req_ready=%b required at most one bit", req_ready);
      end
      if (rsp_valid && rsp_ready) begin
        pop_edges.push_back(cyc + 1);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: data=%h id=%0d tag=%0d required no response", rsp_data, rsp_id, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          if (rsp_data !== e.data || int'(rsp_id) != e.id || rsp_tag !== e.tag) begin
            n_fail++;
            $display("FAIL rsp_order: got data=%h id=%0d tag=%0d required data=%h id=%0d tag=%0d",
                     rsp_data, rsp_id, rsp_tag, e.data, e.id, e.tag);
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back('{i, req_tag[i*TAG_W +: TAG_W],
                            core_fn(req_state[i*128 +: 128], req_key[i*128 +: 128])});
          grant_log.push_back(i);
          issue_edges.push_back(cyc + 1);
          issue_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int w = 0; w < 300 && !done; w++) begin
      if (!busy && !rsp_valid) done = 1'b1;
      else step();
    end
    check("idle_timeout", done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [4];
    logic         got;
    logic [127:0] d;
    logic [NUM_REQ-1:0] grant;
    int           lat;
    int           rid;
    int           tg;
    int           base;
    int           bad;

    vecs[0] = '{0, FIPS_PT, FIPS_KEY, 4'd5, FIPS_CT};
    vecs[1] = '{1, 128'h1, 128'h2, 4'd9, 128'h3};
    vecs[2] = '{0, {4{32'hffffffff}}, {4{32'h0f0f0f0f}}, 4'd3, {4{32'hf0f0f0f0}}};
    vecs[3] = '{1, 128'hdeadbeef_00000000_00000000_00000000,
                   128'hdeadbeef_00000000_00000000_00000001, 4'd15, 128'h1};

    // Reset with requests pending: nothing may be granted
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    req_state = '0; req_key = '0; req_tag = '0;
    step(); step(); step();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_core_state", core_state, 128'h0);
    check("rst_core_key", core_key, 128'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 128'h0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_tag", rsp_tag, 4'd0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0; req_valid = '0;
    step();

    // Table-driven single requests: grant, latency and payload
    rsp_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      req_valid = '0;
      req_valid[vecs[v].req] = 1'b1;
      req_state[vecs[v].req*128 +: 128] = vecs[v].state;
      req_key[vecs[v].req*128 +: 128]   = vecs[v].key;
      req_tag[vecs[v].req*TAG_W +: TAG_W] = vecs[v].tag;
      got = 1'b0; grant = '0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        got = req_ready[vecs[v].req];
        grant = req_ready;
        step();
      end
      req_valid = '0;
      check("vec_issue", got, 1'b1);
      check("vec_grant", grant, 128'(1) << vecs[v].req);
      got = 1'b0; lat = 0; d = '0; rid = 0; tg = 0;
      for (int w = 0; w < 100 && !got; w++) begin
        @(negedge clk);
        got = rsp_valid; d = rsp_data; rid = int'(rsp_id); tg = int'(rsp_tag);
        step();
        lat++;
      end
      check("vec_latency", lat, 22);
      check("vec_data", d, vecs[v].exp_data);
      check("vec_id", rid, vecs[v].req);
      check("vec_tag", tg, vecs[v].tag);
      $display("[TB] vector %0d: req=%0d latency=%0d data=%h", v, vecs[v].req, lat, d);
      wait_idle();
    end

    // Contention: both requesters every cycle, grants alternate
    grant_log.delete(); pop_edges.delete();
    req_valid = 2'b11;
    req_key = {2{ {4{32'h5a5a5a5a}} }};
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_state[i*128 +: 128] = {64'h0, 32'(i), 32'(c)};
        req_tag[i*TAG_W +: TAG_W] = 4'(c);
      end
      step();
    end
    req_valid = '0;
    wait_idle();
    check("cont_grants", grant_log.size(), 10);
    for (int k = 0; k < grant_log.size(); k++) check("cont_alternate", grant_log[k], k % 2);
    check("cont_rsp_count", pop_edges.size(), 10);
    if (pop_edges.size() == 10) check("cont_back_to_back", pop_edges[9] - pop_edges[0], 9);
    $display("[TB] contention: %0d grants, %0d responses", grant_log.size(), pop_edges.size());

    // Backpressure: credit stops issue at FIFO_DEPTH, reopens after a pop
    rsp_ready = 1'b0; issue_edges.delete(); pop_edges.delete();
    base = issue_cnt;
    req_valid = 2'b01;
    for (int c = 0; c < 60; c++) begin
      req_state[127:0] = {96'h0, 32'(1000 + c)};
      req_tag[TAG_W-1:0] = 4'(c);
      step();
    end
    check("bp_issue_count", issue_cnt - base, 32);
    check("bp_ready_low", req_ready, 2'b00);
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_state[127:0] = {96'h0, 32'(2000 + c)};
      step();
    end
    req_valid = '0;
    wait_idle();
    check("bp_pops", pop_edges.size(), issue_edges.size());
    if (issue_edges.size() > 32 && pop_edges.size() > 0)
      check("bp_reissue_edge", issue_edges[32], pop_edges[0] + 1);
    else
      check("bp_reissue_seen", issue_edges.size() > 32, 1'b1);
    $display("[TB] backpressure: %0d issues, %0d responses", issue_edges.size(), pop_edges.size());

    // Boundary: credit 31 with 10 queued, issue and pop on the same edge
    rsp_ready = 1'b0; req_valid = 2'b01;
    for (int c = 0; c < 31; c++) begin
      req_state[127:0] = {96'h0, 32'(3000 + c)};
      step();
    end
    check("bnd_credit_pre", dut.credit_used, 31);
    check("bnd_fifo_pre", dut.fifo_count, 10);
    rsp_ready = 1'b1;
    req_state[127:0] = {96'h0, 32'(3100)};
    @(negedge clk);
    check("bnd_issue_ok", req_ready, 2'b01);
    check("bnd_pop_ok", rsp_valid, 1'b1);
    step();
    check("bnd_credit_hold", dut.credit_used, 31);
    check("bnd_fifo_hold", dut.fifo_count, 10);
    rsp_ready = 1'b0;
    req_state[127:0] = {96'h0, 32'(3101)};
    check("bnd_next_issue", req_ready, 2'b01);
    step();
    check("bnd_credit_full", dut.credit_used, 32);
    check("bnd_ready_full", req_ready, 2'b00);
    req_valid = '0; rsp_ready = 1'b1;
    wait_idle();
    $display("[TB] boundary: credit held at 31 across issue+pop");

    // Reset mid-flight: 6 in the core, 3 queued, all dropped
    rsp_ready = 1'b0; req_valid = 2'b01;
    for (int c = 0; c < 9; c++) begin
      req_state[127:0] = {96'h0, 32'(4000 + c)};
      step();
    end
    req_valid = '0;
    for (int c = 0; c < 15; c++) step();
    check("mid_fifo_pre", dut.fifo_count, 3);
    check("mid_credit_pre", dut.credit_used, 9);
    rst = 1'b1;
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    check("mid_busy", busy, 1'b0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) bad++;
      step();
    end
    check("mid_silent", bad, 0);
    req_valid = 2'b11;
    @(negedge clk);
    check("mid_first_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] reset mid-flight: %0d cycles with a response after reset", bad);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
